// File: rtl/parking_occupancy_counter.sv
// Lot occupancy bookkeeping fed by car_enter/car_exit pulses, with saturating count and sticky errors.
// Optional peak-occupancy output is enabled by defining OCC_PEAK_EN.
module parking_occupancy_counter #(
  parameter int CAPACITY = 15,
  parameter int WIDTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_enter,
  input  logic             car_exit,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] avail,
  output logic             full,
  output logic             empty,
  output logic             overflow_err,
`ifdef OCC_PEAK_EN
  output logic             underflow_err,
  output logic [WIDTH-1:0] peak
`else
  output logic             underflow_err
`endif
);

  localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACITY);

  logic             r_enter_d;
  logic             r_exit_d;
  logic [WIDTH-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_enter_evt;
  logic             w_exit_evt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_ovf_set;
  logic             w_unf_set;

  // A level held across several cycles produces exactly one event.
  assign w_enter_evt = car_enter & ~r_enter_d;
  assign w_exit_evt  = car_exit  & ~r_exit_d;

  always_comb begin
    w_count_nxt = r_count;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    if (w_enter_evt && !w_exit_evt) begin
      if (r_count == CAP_W) w_ovf_set = 1'b1;
      else                  w_count_nxt = r_count + WIDTH'(1);
    end else if (w_exit_evt && !w_enter_evt) begin
      if (r_count == '0) w_unf_set = 1'b1;
      else               w_count_nxt = r_count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enter_d   <= 1'b0;
      r_exit_d    <= 1'b0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_enter_d   <= car_enter;
      r_exit_d    <= car_exit;
      r_count     <= w_count_nxt;
      // A new error in the same cycle as err_clr keeps the flag set.
      r_overflow  <= w_ovf_set | (r_overflow  & ~err_clr);
      r_underflow <= w_unf_set | (r_underflow & ~err_clr);
    end
  end

`ifdef OCC_PEAK_EN
  logic [WIDTH-1:0] r_peak;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_peak <= '0;
    else if (w_count_nxt > r_peak) r_peak <= w_count_nxt;
  end

  assign peak = r_peak;
`endif

  assign count         = r_count;
  assign avail         = CAP_W - r_count;
  assign full          = (r_count == CAP_W);
  assign empty         = (r_count == '0);
  assign overflow_err  = r_overflow;
  assign underflow_err = r_underflow;

endmodule

// File: doc/parking_occupancy_counter.md
Name: parking_occupancy_counter

Overview:
- Downstream consumer of the car entry/exit detector FSM.
- Takes its single-cycle car_enter / car_exit event pulses and keeps a running lot occupancy count against a fixed capacity.
- Drives full/empty status, spaces-available count and sticky overflow/underflow error flags for the gate and display logic.
- Purely synchronous bookkeeping stage, one clock domain.

Parameters:
- CAPACITY, 15, maximum number of cars in the lot; legal range 1..(2**WIDTH)-1.
- WIDTH, 4, bit width of count and avail.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- car_enter  input  1  entry event from the detector FSM; nominally a 1-cycle pulse.
- car_exit  input  1  exit event from the detector FSM; nominally a 1-cycle pulse.
- err_clr  input  1  synchronous clear of the sticky error flags.
- count  output  WIDTH  current occupancy.
- avail  output  WIDTH  free spaces, CAPACITY - count.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.
- overflow_err  output  1  sticky: an entry was seen while full.
- underflow_err  output  1  sticky: an exit was seen while empty.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset (async, immediate) sets:
  - count = 0, avail = CAPACITY, full = 0, empty = 1 (full = 1 only if CAPACITY == 0, which is illegal);
  - overflow_err = 0, underflow_err = 0;
  - both edge-detect registers = 0.
- Edge detect: registered copies enter_d / exit_d.
  - enter_evt = car_enter & ~enter_d; exit_evt = car_exit & ~exit_d.
  - An input held high for N cycles counts once.
  - An input high when reset deasserts counts once, on the first clock edge after release.
- Latency: count changes on the same rising edge at which the input is first sampled high, so the result is visible 1 cycle after the input rises.
- full, empty and avail decode combinationally from the registered count; no extra latency.
- Update rules, per clock edge:
  - enter_evt only, count < CAPACITY: count + 1.
  - enter_evt only, count == CAPACITY: count holds; overflow_err <= 1.
  - exit_evt only, count > 0: count - 1.
  - exit_evt only, count == 0: count holds; underflow_err <= 1.
  - enter_evt and exit_evt together: net zero, count holds, no error set, even at full or empty.
  - Neither: hold.
- No wrap-around under any circumstance: count is saturated by the rules above and never leaves 0..CAPACITY.
- Error flags:
  - Sticky until reset or err_clr.
  - err_clr clears both flags on the next edge.
  - If err_clr and a new error event occur in the same cycle, set wins and the flag reads 1.
- err_clr has no effect on count.
- Reset mid-operation, including during an input pulse: all state is cleared immediately; the pending event is lost unless the input is still high after release.

Optional Feature:
- Macro: OCC_PEAK_EN.
- Defined:
  - Adds output port peak (WIDTH bits): highest count reached since reset.
  - Updated on the same edge as count: peak <= max(peak, next count).
  - Reset value 0; not affected by err_clr.
- Undefined: peak port and register are absent; all other behaviour is identical.

Test Plan (CAPACITY=3, WIDTH=2 unless stated):
- Reset, then 3 single-cycle car_enter pulses spaced 2 cycles apart -> count 1,2,3, each 1 cycle after its pulse; full=1, avail=0, empty=0.
- From full, 1 more car_enter -> count stays 3, overflow_err=1. Pulse err_clr -> overflow_err=0 next cycle. Error event and err_clr in the same cycle -> flag stays 1.
- From reset, 1 car_exit -> count stays 0, underflow_err=1, empty=1. Then car_enter held high 5 cycles -> count=1 only.
- count=1, car_enter and car_exit asserted on the same edge -> count stays 1, no error flags. Repeat at count=0 and count=3 -> count unchanged, no errors.
- count=2, assert reset asynchronously between clock edges -> count=0, avail=3, flags 0 immediately, before the next edge. car_enter high across reset release -> count=1 after the first edge.
- OCC_PEAK_EN defined, CAPACITY=15, WIDTH=4: enter 5, exit 3, enter 1 -> count=3, peak=5. Reset -> peak=0.
